// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pkg
// Shared definitions for the decode-stage register file / scoreboard:
//   - condition code encodings {N,Z,P}
//   - post-flush grace length
//   - writeback hit counting helper
//   - packed-port slicing macros (expect IDX_W / DATA_W in the caller's scope)
// No ports (package).
// -----------------------------------------------------------------------------

`define RSB_IDX(vec, i)  vec[(i)*IDX_W +: IDX_W]
`define RSB_DATA(vec, i) vec[(i)*DATA_W +: DATA_W]

package regfile_scoreboard_pkg;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  // Upper bound on writeback ports the hit counter understands.
  localparam int MAX_WB = 8;

  // Cycles after a flush during which late writebacks may underflow silently.
  localparam int GRACE_CYCLES = 8;

  // Number of enabled writeback ports whose index matched a given register.
  // Callers pad en/match to MAX_WB bits.
  function automatic logic [3:0] wb_hit_count(input logic [MAX_WB-1:0] en,
                                              input logic [MAX_WB-1:0] match);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_WB; i++) begin
      n = n + {3'b000, en[i] & match[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// -----------------------------------------------------------------------------
// scoreboard_counter
// One pending-write counter: +inc, -dec per cycle, clamped to [0, 2^CNT_W-1].
// Ports:
//   clk, rst_n   clock / synchronous active-low reset
//   clear        force count to zero (flush); suppresses err
//   inc          one new in-flight write accepted this cycle
//   dec          number of writebacks hitting this register this cycle
//   err_mask     suppress err (post-flush grace window)
//   count        current pending count
//   err          combinational: this cycle's update would go below zero
// -----------------------------------------------------------------------------
module scoreboard_counter
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  input  logic             err_mask,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 2;
  localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'((1 << CNT_W) - 1);

  logic [SUM_W-1:0] up_ext;
  logic [SUM_W-1:0] dec_ext;
  logic [SUM_W-1:0] diff;
  logic             underflow;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    up_ext    = SUM_W'(count) + SUM_W'(inc);
    dec_ext   = SUM_W'(dec);
    underflow = dec_ext > up_ext;
    diff      = up_ext - dec_ext;
    if (underflow) begin
      count_nxt = '0;
    end else if (diff > MAX_EXT) begin
      count_nxt = '1;
    end else begin
      count_nxt = diff[CNT_W-1:0];
    end
  end

  assign err = underflow & ~err_mask & ~clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Decode-stage register file with per-register pending-write counters,
// writeback-to-read bypass, CC dependency check, flush, and a registered
// valid/ready operand stage toward execute.
// Ports:
//   I_CLOCK, I_RESET_N         clock / synchronous active-low reset
//   I_IssueValid               decode presents an instruction
//   I_IssueSrcUse/SrcIdx       per read port use flag and register index
//   I_IssueDestEn/DestIdx      destination write enable and index
//   I_IssueCCUse               instruction depends on CC
//   O_IssueReady               instruction accepted when high with valid
//   I_WbEnable/WbIdx/WbData    writeback ports (highest port wins collisions)
//   I_Flush                    drop all pending ownership, block issue
//   O_OutValid/I_OutReady      output register handshake
//   O_SrcData, O_CC            registered operands and CC at accept
//   O_Error                    sticky writeback-without-pending flag
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  parameter  int DATA_W   = 16,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WB   = 2,
  parameter  int CNT_W    = 2,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET_N,
  input  logic                     I_IssueValid,
  input  logic [NUM_RD-1:0]        I_IssueSrcUse,
  input  logic [NUM_RD*IDX_W-1:0]  I_IssueSrcIdx,
  input  logic                     I_IssueDestEn,
  input  logic [IDX_W-1:0]         I_IssueDestIdx,
  input  logic                     I_IssueCCUse,
  output logic                     O_IssueReady,
  input  logic [NUM_WB-1:0]        I_WbEnable,
  input  logic [NUM_WB*IDX_W-1:0]  I_WbIdx,
  input  logic [NUM_WB*DATA_W-1:0] I_WbData,
  input  logic                     I_Flush,
  output logic                     O_OutValid,
  input  logic                     I_OutReady,
  output logic [NUM_RD*DATA_W-1:0] O_SrcData,
  output logic [2:0]               O_CC,
  output logic                     O_Error
);

  localparam int DEC_W = $clog2(NUM_WB + 1);
  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 2;

  function automatic logic [2:0] cc_classify(input logic signed [DATA_W-1:0] d);
    if (d[DATA_W-1]) begin
      return CC_N;
    end else if (d == '0) begin
      return CC_Z;
    end else begin
      return CC_P;
    end
  endfunction

  logic [DATA_W-1:0]        rf [NUM_REGS];
  logic [2:0]               cc_reg;
  logic [CNT_W-1:0]         pending [NUM_REGS];
  logic [DEC_W-1:0]         hits [NUM_REGS];
  logic [DATA_W-1:0]        wb_win [NUM_REGS];
  logic [NUM_REGS-1:0]      wb_hit_any;
  logic [NUM_REGS-1:0]      ep_nz;
  logic [NUM_REGS-1:0]      inc_vec;
  logic [NUM_REGS-1:0]      cnt_err;
  logic [3:0]               grace_cnt;
  logic                     grace_busy;

  logic                     any_wb;
  logic [DATA_W-1:0]        cc_data;
  logic [2:0]               cc_wb;
  logic [2:0]               cc_cur;
  logic                     src_stall;
  logic                     cc_stall;
  logic                     sat_stall;
  logic                     bp_stall;
  logic                     issue_ready;
  logic                     accept;
  logic [NUM_RD*DATA_W-1:0] src_p0;

  logic                     vld_p1;
  logic [NUM_RD*DATA_W-1:0] src_data_p1;
  logic [2:0]               cc_p1;
  logic                     err_sticky;

  // ---- stage p0: writeback decode, effective pending, stalls, operand mux ----
  always_comb begin
    logic [MAX_WB-1:0] en_pad;
    logic [MAX_WB-1:0] match;
    logic [3:0]        n;
    en_pad = '0;
    en_pad[NUM_WB-1:0] = I_WbEnable;
    for (int r = 0; r < NUM_REGS; r++) begin
      match     = '0;
      wb_win[r] = '0;
      for (int i = 0; i < NUM_WB; i++) begin
        if (`RSB_IDX(I_WbIdx, i) == IDX_W'(r)) begin
          match[i] = 1'b1;
          if (I_WbEnable[i]) begin
            wb_win[r] = `RSB_DATA(I_WbData, i);
          end
        end
      end
      n             = wb_hit_count(en_pad, match);
      hits[r]       = n[DEC_W-1:0];
      wb_hit_any[r] = |n;
      // Pending count net of writebacks landing this cycle, floored at 0.
      ep_nz[r]      = SUM_W'(pending[r]) > SUM_W'(hits[r]);
    end
  end

  always_comb begin
    any_wb  = |I_WbEnable;
    cc_data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (I_WbEnable[i]) begin
        cc_data = `RSB_DATA(I_WbData, i);
      end
    end
    cc_wb  = cc_classify($signed(cc_data));
    cc_cur = any_wb ? cc_wb : cc_reg;
  end

  always_comb begin
    src_stall = 1'b0;
    src_p0    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (I_IssueSrcUse[i]) begin
        if (ep_nz[`RSB_IDX(I_IssueSrcIdx, i)]) begin
          src_stall = 1'b1;
        end
        // A register written this cycle is forwarded instead of the stale RF copy.
        if (wb_hit_any[`RSB_IDX(I_IssueSrcIdx, i)]) begin
          `RSB_DATA(src_p0, i) = wb_win[`RSB_IDX(I_IssueSrcIdx, i)];
        end else begin
          `RSB_DATA(src_p0, i) = rf[`RSB_IDX(I_IssueSrcIdx, i)];
        end
      end
    end
    cc_stall    = I_IssueCCUse && (|ep_nz);
    sat_stall   = I_IssueDestEn && (pending[I_IssueDestIdx] == '1)
                  && !wb_hit_any[I_IssueDestIdx];
    bp_stall    = vld_p1 && !I_OutReady;
    issue_ready = !(src_stall || cc_stall || sat_stall || bp_stall) && !I_Flush;
    accept      = I_IssueValid && issue_ready;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = accept && I_IssueDestEn && (I_IssueDestIdx == IDX_W'(r));
    end
  end

  assign grace_busy = (grace_cnt != 4'd0);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    scoreboard_counter #(
      .CNT_W (CNT_W),
      .DEC_W (DEC_W)
    ) u_cnt (
      .clk      (I_CLOCK),
      .rst_n    (I_RESET_N),
      .clear    (I_Flush),
      .inc      (inc_vec[r]),
      .dec      (hits[r]),
      .err_mask (grace_busy),
      .count    (pending[r]),
      .err      (cnt_err[r])
    );
  end

  // ---- stage p1: register file, CC, grace window, output register ----
  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_N) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        rf[r] <= '0;
      end
      cc_reg      <= '0;
      grace_cnt   <= '0;
      err_sticky  <= 1'b0;
      vld_p1      <= 1'b0;
      src_data_p1 <= '0;
      cc_p1       <= '0;
    end else begin
      // Ascending port order: the highest-numbered colliding port lands last.
      for (int i = 0; i < NUM_WB; i++) begin
        if (I_WbEnable[i]) begin
          rf[`RSB_IDX(I_WbIdx, i)] <= `RSB_DATA(I_WbData, i);
        end
      end
      if (any_wb) begin
        cc_reg <= cc_wb;
      end
      if (I_Flush) begin
        grace_cnt <= 4'(GRACE_CYCLES);
      end else if (grace_busy) begin
        grace_cnt <= grace_cnt - 4'd1;
      end
      if (|cnt_err) begin
        err_sticky <= 1'b1;
      end
      if (accept) begin
        vld_p1      <= 1'b1;
        src_data_p1 <= src_p0;
        cc_p1       <= cc_cur;
      end else if (I_Flush || I_OutReady) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign O_IssueReady = issue_ready;
  assign O_OutValid   = vld_p1;
  assign O_SrcData    = src_data_p1;
  assign O_CC         = cc_p1;
  assign O_Error      = err_sticky;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [1:0]  issue_src_use;
  logic [7:0]  issue_src_idx;
  logic        issue_dest_en;
  logic [3:0]  issue_dest_idx;
  logic        issue_cc_use;
  logic        issue_ready;
  logic [1:0]  wb_enable;
  logic [7:0]  wb_idx;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src_data;
  logic [2:0]  cc;
  logic        error;

  int n_vec = 0;
  int n_err = 0;
  int step  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .I_CLOCK        (clk),
    .I_RESET_N      (rst_n),
    .I_IssueValid   (issue_valid),
    .I_IssueSrcUse  (issue_src_use),
    .I_IssueSrcIdx  (issue_src_idx),
    .I_IssueDestEn  (issue_dest_en),
    .I_IssueDestIdx (issue_dest_idx),
    .I_IssueCCUse   (issue_cc_use),
    .O_IssueReady   (issue_ready),
    .I_WbEnable     (wb_enable),
    .I_WbIdx        (wb_idx),
    .I_WbData       (wb_data),
    .I_Flush        (flush),
    .O_OutValid     (out_valid),
    .I_OutReady     (out_ready),
    .O_SrcData      (src_data),
    .O_CC           (cc),
    .O_Error        (error)
  );

  typedef struct {
    logic        v;
    logic [1:0]  su;
    logic [3:0]  s0, s1;
    logic        de;
    logic [3:0]  di;
    logic        ccu;
    logic [1:0]  we;
    logic [3:0]  w0i, w1i;
    logic [15:0] w0d, w1d;
    logic        fl, ordy;
    logic        e_rdy, e_ov;
    logic [15:0] e_sd0, e_sd1;
    logic [2:0]  e_cc;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int v, su, s0, s1, de, di, ccu,
                              we, w0i, w0d, w1i, w1d, fl, ordy,
                              er, eo, es0, es1, ec, ee);
    vec_t t;
    t.v = 1'(v);   t.su = 2'(su);  t.s0 = 4'(s0);  t.s1 = 4'(s1);
    t.de = 1'(de); t.di = 4'(di);  t.ccu = 1'(ccu);
    t.we = 2'(we); t.w0i = 4'(w0i); t.w0d = 16'(w0d);
    t.w1i = 4'(w1i); t.w1d = 16'(w1d);
    t.fl = 1'(fl); t.ordy = 1'(ordy);
    t.e_rdy = 1'(er); t.e_ov = 1'(eo); t.e_sd0 = 16'(es0); t.e_sd1 = 16'(es1);
    t.e_cc = 3'(ec); t.e_err = 1'(ee);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got 0x%0h, want 0x%0h", nm, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    issue_valid    = t.v;
    issue_src_use  = t.su;
    issue_src_idx  = {t.s1, t.s0};
    issue_dest_en  = t.de;
    issue_dest_idx = t.di;
    issue_cc_use   = t.ccu;
    wb_enable      = t.we;
    wb_idx         = {t.w1i, t.w0i};
    wb_data        = {t.w1d, t.w0d};
    flush          = t.fl;
    out_ready      = t.ordy;
  endtask

  task automatic check_regs(input vec_t t);
    chk("out_valid", 32'(out_valid), 32'(t.e_ov));
    chk("src0", 32'(src_data[15:0]), 32'(t.e_sd0));
    chk("src1", 32'(src_data[31:16]), 32'(t.e_sd1));
    chk("cc", 32'(cc), 32'(t.e_cc));
    chk("error", 32'(error), 32'(t.e_err));
  endtask

  // One cycle: drive mid-low-phase, check the combinational ready, then the
  // registered outputs just after the rising edge.
  task automatic apply(input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    chk("issue_ready", 32'(issue_ready), 32'(t.e_rdy));
    @(posedge clk);
    #1;
    check_regs(t);
    n_vec++;
    step++;
  endtask

  // Reset asserted with a live issue request to show reset dominates.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(1,3,1,4, 1,2, 0, 3,1,9,2,7, 0,1, 0,0,0,0,0,0));
    @(posedge clk);
    @(posedge clk);
    #1;
    check_regs(mk(0,0,0,0, 0,0, 0, 0,0,0,0,0, 0,1, 0,0,0,0,0,0));
    n_vec++;
    step++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0,0,0,0, 0,0, 0, 0,0,0,0,0, 0,1, 0,0,0,0,0,0));
    #1;
    chk("ready_after_reset", 32'(issue_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk(0,0,0,0, 0,0, 0, 0,0,0,0,0, 0,1, 0,0,0,0,0,0));

    //        v su s0 s1 de di cc we w0i w0d    w1i w1d     fl or  rdy ov sd0     sd1 cc err
    // reset then read R3,R5
    tbl.push_back(mk(1,3,3,5, 0,0, 0, 0,0,0,      0,0,       0,1, 1,1,0,      0,0,0));
    // RAW with bypass on R2
    tbl.push_back(mk(1,0,0,0, 1,2, 0, 0,0,0,      0,0,       0,1, 1,1,0,      0,0,0));
    tbl.push_back(mk(1,1,2,0, 0,0, 0, 1,2,'h42,   0,0,       0,1, 1,1,'h42,   0,1,0));
    tbl.push_back(mk(1,1,2,0, 0,0, 0, 0,0,0,      0,0,       0,1, 1,1,'h42,   0,1,0));
    // three in-flight writes to R4, fourth blocked until a writeback lands
    tbl.push_back(mk(1,0,0,0, 1,4, 0, 0,0,0,      0,0,       0,1, 1,1,0,      0,1,0));
    tbl.push_back(mk(1,0,0,0, 1,4, 0, 0,0,0,      0,0,       0,1, 1,1,0,      0,1,0));
    tbl.push_back(mk(1,0,0,0, 1,4, 0, 0,0,0,      0,0,       0,1, 1,1,0,      0,1,0));
    tbl.push_back(mk(1,0,0,0, 1,4, 0, 0,0,0,      0,0,       0,1, 0,0,0,      0,1,0));
    tbl.push_back(mk(1,0,0,0, 1,4, 0, 1,4,7,      0,0,       0,1, 1,1,0,      0,1,0));
    tbl.push_back(mk(1,0,0,0, 1,4, 0, 0,0,0,      0,0,       0,1, 0,0,0,      0,1,0));
    // drain R4: two then one, then read it back
    tbl.push_back(mk(0,0,0,0, 0,0, 0, 3,4,1,      4,2,       0,1, 1,0,0,      0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 0, 1,4,3,      0,0,       0,1, 1,0,0,      0,1,0));
    tbl.push_back(mk(1,1,4,0, 0,0, 0, 0,0,0,      0,0,       0,1, 1,1,3,      0,1,0));
    // dual writeback to R1 with two pending, bypassed read of R1 and R4
    tbl.push_back(mk(1,0,0,0, 1,1, 0, 0,0,0,      0,0,       0,1, 1,1,0,      0,1,0));
    tbl.push_back(mk(1,0,0,0, 1,1, 0, 0,0,0,      0,0,       0,1, 1,1,0,      0,1,0));
    tbl.push_back(mk(1,3,1,4, 0,0, 0, 3,1,5,      1,'hFFFE,  0,1, 1,1,'hFFFE, 3,4,0));
    tbl.push_back(mk(1,1,1,0, 0,0, 0, 0,0,0,      0,0,       0,1, 1,1,'hFFFE, 0,4,0));
    // CC stall on pending R6, flush, then late writeback in the grace window
    tbl.push_back(mk(1,0,0,0, 1,6, 0, 0,0,0,      0,0,       0,1, 1,1,0,      0,4,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1, 0,0,0,      0,0,       0,1, 0,0,0,      0,4,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1, 0,0,0,      0,0,       1,1, 0,0,0,      0,4,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1, 0,0,0,      0,0,       0,1, 1,1,0,      0,4,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 0, 1,6,0,      0,0,       0,1, 1,0,0,      0,4,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1, 0,0,0,      0,0,       0,1, 1,1,0,      0,2,0));
    tbl.push_back(mk(1,3,1,4, 0,0, 0, 0,0,0,      0,0,       0,1, 1,1,'hFFFE, 3,2,0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Backpressure: outputs must hold while execute is not ready.
    for (int i = 0; i < 5; i++) begin
      apply(mk(1,3,2,2, 0,0, 0, 0,0,0, 0,0, 0,0, 0,1,'hFFFE,3,2,0));
    end
    apply(mk(0,0,0,0, 0,0, 0, 0,0,0, 0,0, 0,1, 1,0,'hFFFE,3,2,0));

    // Let the post-flush grace window expire.
    for (int i = 0; i < 4; i++) begin
      apply(mk(0,0,0,0, 0,0, 0, 0,0,0, 0,0, 0,1, 1,0,'hFFFE,3,2,0));
    end

    // Writeback to R9 with nothing pending: sticky error.
    apply(mk(0,0,0,0, 0,0, 0, 1,9,1, 0,0, 0,1, 1,0,'hFFFE,3,2,1));
    for (int i = 0; i < 3; i++) begin
      apply(mk(0,0,0,0, 0,0, 0, 0,0,0, 0,0, 0,1, 1,0,'hFFFE,3,2,1));
    end

    // Only reset clears the error; RF is zero again afterwards.
    do_reset();
    apply(mk(1,3,1,9, 0,0, 1, 0,0,0, 0,0, 0,1, 1,1,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
